rc5_key_loader: RTL and testbench

Writer-side front end for the RC5 key RAM. Accepts a secret key one byte per transfer over a valid/ready handshake and writes it into the B-byte key RAM through that RAM's write port, using addresses 0..B-1. Completion is signalled with a one-cycle start pulse for the key expander, which reads the same RAM. It sits between the host/testbench byte source and the key RAM, ahead of the key expander → cipher → decipher chain.

---
 rtl/rc5_key_loader_if.sv | 45 ++++
 rtl/rc5_key_loader.sv | 185 ++++++++++++++++++
 tb/tb_rc5_key_loader.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc5_key_loader_if.sv
// rc5_key_loader_if
//
// Bundles the two byte-wide paths of the RC5 key loader:
//   - key byte stream from the host (iKey_byte / iKey_valid / oKey_ready)
//   - write port of the B-byte key RAM (oKey_address / oKey_data / oKey_we)
//
// Handshake: a byte moves on a rising clk edge exactly when iKey_valid and
// oKey_ready are both high at that edge. The source may raise iKey_valid at
// any time. Once raised, it holds iKey_byte stable until the transfer
// completes. The loader raises oKey_ready without looking at iKey_valid.
//
// Parameters:
//   B_LENGTH  key RAM address width, $clog2(B).
//
// Modports:
//   slave   the loader: consumes the byte stream and drives the RAM port.
//   master  the environment: byte source plus key RAM.
interface rc5_key_loader_if #(
    parameter int B_LENGTH = 4
);
    logic [7:0]          iKey_byte;
    logic                iKey_valid;
    logic                oKey_ready;
    logic [B_LENGTH-1:0] oKey_address;
    logic [7:0]          oKey_data;
    logic                oKey_we;

    modport slave (
        input  iKey_byte,
        input  iKey_valid,
        output oKey_ready,
        output oKey_address,
        output oKey_data,
        output oKey_we
    );

    modport master (
        output iKey_byte,
        output iKey_valid,
        input  oKey_ready,
        input  oKey_address,
        input  oKey_data,
        input  oKey_we
    );
endinterface

// File: rtl/rc5_key_loader.sv
// rc5_key_loader
//
// Writer-side front end for the RC5 key RAM. It takes the secret key one byte
// per handshake. Byte k is key[k], in RC5 little-endian order. It writes byte
// k to RAM address k. When all B bytes are stored, it pulses oStartExpander
// for one cycle so the key expander can start reading the same RAM.
//
// Optional feature, macro RC5_KEY_LOADER_ZEROIZE_EN:
//   When defined, a CLEAR state writes 0x00 to every RAM address before each
//   load and after every abort, so no partial key survives. When undefined,
//   CLEAR does not exist and aborted loads leave partial key bytes in RAM.
//
// Parameters:
//   B         key length in bytes (>= 2).
//   B_LENGTH  key RAM address width, $clog2(B).
//
// Ports:
//   clk             single clock, rising edge.
//   rst             synchronous active-high reset. It clears the FSM only.
//   iStart          starts a new load. Sampled in IDLE and DONE.
//   iAbort          cancels a load. Sampled in CLEAR, LOAD and FIN.
//   bus             byte stream in, key RAM write port out (registered).
//   oStartExpander  one-cycle pulse when the full key is in RAM.
//   oBusy           high in CLEAR, LOAD and FIN.
//   oDone           high in DONE, held until the next iStart.
//   state_dbg       current FSM state encoding, for observation only.
module rc5_key_loader #(
    parameter int B        = 16,
    parameter int B_LENGTH = $clog2(B)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iStart,
    input  logic            iAbort,
    rc5_key_loader_if.slave bus,
    output logic            oStartExpander,
    output logic            oBusy,
    output logic            oDone,
    output logic [2:0]      state_dbg
);

    // Explicit codes keep the encoding stable whether or not CLEAR is built.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
`ifdef RC5_KEY_LOADER_ZEROIZE_EN
        ST_CLEAR = 3'd1,
`endif
        ST_LOAD  = 3'd2,
        ST_FIN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // The counter is compared against the last address instead of relying
    // on wrap-around, so a B that is not a power of two also works.
    localparam logic [B_LENGTH-1:0] LAST_ADDR = B_LENGTH'(B - 1);

    state_t              state;
    logic [B_LENGTH-1:0] count;

`ifdef RC5_KEY_LOADER_ZEROIZE_EN
    // Where the sweep goes when it ends: 1 = LOAD (after a start),
    // 0 = IDLE (after an abort).
    logic                clear_to_load;
`endif

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            count            <= '0;
            bus.oKey_ready   <= 1'b0;
            bus.oKey_address <= '0;
            bus.oKey_data    <= 8'h00;
            bus.oKey_we      <= 1'b0;
            oStartExpander   <= 1'b0;
            oBusy            <= 1'b0;
            oDone            <= 1'b0;
`ifdef RC5_KEY_LOADER_ZEROIZE_EN
            clear_to_load    <= 1'b0;
`endif
        end else begin
            // A write strobe or start pulse lasts one cycle unless a branch
            // below sets it again.
            bus.oKey_we    <= 1'b0;
            oStartExpander <= 1'b0;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (iStart) begin
                        count <= '0;
                        oDone <= 1'b0;
                        oBusy <= 1'b1;
`ifdef RC5_KEY_LOADER_ZEROIZE_EN
                        // The first zero write goes out now, so all B sweep
                        // writes fall inside the B CLEAR cycles.
                        state            <= ST_CLEAR;
                        clear_to_load    <= 1'b1;
                        bus.oKey_we      <= 1'b1;
                        bus.oKey_address <= '0;
                        bus.oKey_data    <= 8'h00;
`else
                        state            <= ST_LOAD;
                        bus.oKey_ready   <= 1'b1;
`endif
                    end
                end

`ifdef RC5_KEY_LOADER_ZEROIZE_EN
                ST_CLEAR: begin
                    // count holds the address of the zero write being
                    // presented this cycle.
                    if (count == LAST_ADDR) begin
                        count <= '0;
                        if (clear_to_load && !iAbort) begin
                            state          <= ST_LOAD;
                            bus.oKey_ready <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            oBusy <= 1'b0;
                        end
                    end else begin
                        count            <= count + 1'b1;
                        bus.oKey_we      <= 1'b1;
                        bus.oKey_address <= count + 1'b1;
                        bus.oKey_data    <= 8'h00;
                        // An abort cannot cut the sweep short. It only
                        // changes where the sweep goes when it ends.
                        if (iAbort) begin
                            clear_to_load <= 1'b0;
                        end
                    end
                end
`endif

                ST_LOAD, ST_FIN: begin
                    if (iAbort) begin
                        // Abort wins over a byte offered on the same edge.
                        bus.oKey_ready <= 1'b0;
                        count          <= '0;
`ifdef RC5_KEY_LOADER_ZEROIZE_EN
                        state            <= ST_CLEAR;
                        clear_to_load    <= 1'b0;
                        bus.oKey_we      <= 1'b1;
                        bus.oKey_address <= '0;
                        bus.oKey_data    <= 8'h00;
`else
                        state            <= ST_IDLE;
                        oBusy            <= 1'b0;
`endif
                    end else if (state == ST_LOAD) begin
                        // oKey_ready is high throughout LOAD, so valid alone
                        // completes the handshake here.
                        if (bus.iKey_valid) begin
                            bus.oKey_we      <= 1'b1;
                            bus.oKey_address <= count;
                            bus.oKey_data    <= bus.iKey_byte;
                            if (count == LAST_ADDR) begin
                                state          <= ST_FIN;
                                bus.oKey_ready <= 1'b0;
                                count          <= '0;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end else begin
                        // FIN: the last byte was written on this edge. The
                        // expander may now start.
                        state          <= ST_DONE;
                        oStartExpander <= 1'b1;
                        oDone          <= 1'b1;
                        oBusy          <= 1'b0;
                    end
                end

                default: begin
                    state          <= ST_IDLE;
                    bus.oKey_ready <= 1'b0;
                    oBusy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_key_loader.sv
// tb_rc5_key_loader
//
// Self-checking bench for rc5_key_loader with B = 16. Directed scenarios use
// random key bytes and random bubbles. A behavioural model keeps the expected
// RAM image and the expected sequence of RAM writes. A RAM emulator records
// the writes actually issued by the loader.
module tb_rc5_key_loader;

    localparam int B  = 16;
    localparam int BL = $clog2(B);
    localparam int WW = BL + 8;
`ifdef RC5_KEY_LOADER_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif
    localparam int SWEEP = ZEROIZE ? B : 0;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       iStart;
    logic       iAbort;
    logic       oStartExpander;
    logic       oBusy;
    logic       oDone;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    rc5_key_loader_if #(.B_LENGTH(BL)) bus ();

    rc5_key_loader #(.B(B), .B_LENGTH(BL)) dut (
        .clk            (clk),
        .rst            (rst),
        .iStart         (iStart),
        .iAbort         (iAbort),
        .bus            (bus.slave),
        .oStartExpander (oStartExpander),
        .oBusy          (oBusy),
        .oDone          (oDone),
        .state_dbg      (state_dbg)
    );

    // ---------------- key RAM emulator / observers ----------------
    logic [7:0]    ram [B];
    logic [WW-1:0] obs_q[$];
    int            start_cnt = 0;

    always @(posedge clk) begin
        if (bus.oKey_we) begin
            ram[bus.oKey_address] <= bus.oKey_data;
            obs_q.push_back({bus.oKey_address, bus.oKey_data});
        end
        if (oStartExpander) start_cnt <= start_cnt + 1;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [WW-1:0] exp_q[$];
    logic [7:0]    exp_ram [B];
    logic [7:0]    key [B];
    int            exp_starts = 0;
    int            obs_rd = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_write(input int addr, input logic [7:0] data);
        exp_q.push_back({addr[BL-1:0], data});
        exp_ram[addr] = data;
    endfunction

    function automatic void model_sweep();
        for (int i = 0; i < SWEEP; i++) model_write(i, 8'h00);
    endfunction

    task automatic drain(input string tag);
        int n_obs;
        int n_exp;
        n_obs = obs_q.size() - obs_rd;
        n_exp = exp_q.size();
        check({tag, "_write_count"}, n_obs, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i < n_obs) check({tag, "_write"}, obs_q[obs_rd + i], exp_q[i]);
        end
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < B; i++) check(tag, ram[i], exp_ram[i]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        iStart = 1'b1;
        model_sweep();
        tick();
        iStart = 1'b0;
    endtask

    // Waits for oKey_ready after a start edge. The wait is bounded, and the
    // latency is checked.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        check({tag, "_busy"}, oBusy, 1'b1);
        check({tag, "_done_low"}, oDone, 1'b0);
        while (!bus.oKey_ready && n < B + 4) begin
            check({tag, "_sweep_we"}, bus.oKey_we, 1'b1);
            tick();
            n++;
        end
        check({tag, "_ready_latency"}, n, SWEEP);
    endtask

    // Offers key[0..n-1] with optional random bubbles. Returns the number of
    // cycles spent.
    task automatic feed(input string tag, input int n, input bit bubbles, output int cycles);
        int  acc;
        bit  v;
        logic rdy;
        acc = 0;
        cycles = 0;
        while (acc < n && cycles < 200) begin
            v = bubbles ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.iKey_valid = v;
            bus.iKey_byte  = v ? key[acc] : 8'($urandom);
            rdy = bus.oKey_ready;
            check({tag, "_ready"}, rdy, 1'b1);
            tick();
            cycles++;
            if (v && rdy) begin
                check({tag, "_we"}, bus.oKey_we, 1'b1);
                check({tag, "_addr"}, bus.oKey_address, acc);
                check({tag, "_data"}, bus.oKey_data, key[acc]);
                model_write(acc, key[acc]);
                acc++;
            end else begin
                check({tag, "_bubble_we"}, bus.oKey_we, 1'b0);
            end
        end
        bus.iKey_valid = 1'b0;
        check({tag, "_accepted"}, acc, n);
    endtask

    // Called in the FIN cycle. Checks the completion pulse in the next cycle.
    task automatic finish_load(input string tag);
        check({tag, "_fin_busy"}, oBusy, 1'b1);
        check({tag, "_fin_ready"}, bus.oKey_ready, 1'b0);
        tick();
        exp_starts++;
        check({tag, "_start_pulse"}, oStartExpander, 1'b1);
        check({tag, "_done"}, oDone, 1'b1);
        check({tag, "_we_off"}, bus.oKey_we, 1'b0);
        check({tag, "_busy_off"}, oBusy, 1'b0);
    endtask

    // Called after an abort edge. Waits out the sweep (if any) and checks
    // the quiet idle afterwards.
    task automatic after_abort(input string tag);
        int n;
        check({tag, "_no_start"}, oStartExpander, 1'b0);
        check({tag, "_done_low"}, oDone, 1'b0);
        check({tag, "_ready_low"}, bus.oKey_ready, 1'b0);
        model_sweep();
        n = 0;
        while (oBusy && n < B + 4) begin
            tick();
            n++;
        end
        check({tag, "_sweep_cycles"}, n, SWEEP);
        bus.iKey_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_idle_we"}, bus.oKey_we, 1'b0);
            check({tag, "_idle_start"}, oStartExpander, 1'b0);
        end
        bus.iKey_valid = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        rst = 1'b1;
        iStart = 1'b0;
        iAbort = 1'b0;
        bus.iKey_valid = 1'b0;
        bus.iKey_byte = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", bus.oKey_ready, 1'b0);
        check("rst_addr", bus.oKey_address, 0);
        check("rst_data", bus.oKey_data, 8'h00);
        check("rst_we", bus.oKey_we, 1'b0);
        check("rst_start", oStartExpander, 1'b0);
        check("rst_busy", oBusy, 1'b0);
        check("rst_done", oDone, 1'b0);

        // Continuous load: bytes 0x00..0x0F, one byte per cycle.
        for (int i = 0; i < B; i++) key[i] = 8'(i);
        pulse_start();
        wait_ready("t1");
        feed("t1", B, 1'b0, cyc);
        check("t1_throughput", cyc, B);
        finish_load("t1");
        bus.iKey_valid = 1'b1;
        tick();
        check("t1_pulse_once", oStartExpander, 1'b0);
        check("t1_done_held", oDone, 1'b1);
        check("t1_done_we", bus.oKey_we, 1'b0);
        bus.iKey_valid = 1'b0;
        drain("t1");
        check_ram("t1_ram");
        check("t1_starts", start_cnt, exp_starts);

        // Random key with random bubbles.
        for (int i = 0; i < B; i++) key[i] = 8'($urandom);
        pulse_start();
        wait_ready("t2");
        feed("t2", B, 1'b1, cyc);
        finish_load("t2");
        tick();
        drain("t2");
        check_ram("t2_ram");
        check("t2_starts", start_cnt, exp_starts);

        // Abort after 5 bytes. A valid byte is offered on the abort edge.
        for (int i = 0; i < B; i++) key[i] = 8'($urandom);
        pulse_start();
        wait_ready("t3");
        feed("t3", 5, 1'b1, cyc);
        bus.iKey_valid = 1'b1;
        bus.iKey_byte = 8'hAA;
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        bus.iKey_valid = 1'b0;
        after_abort("t3");
        drain("t3");
        check_ram("t3_ram");
        check("t3_starts", start_cnt, exp_starts);

        // Abort during FIN: the last write lands, but there is no start pulse.
        for (int i = 0; i < B; i++) key[i] = 8'($urandom);
        pulse_start();
        wait_ready("t4");
        feed("t4", B, 1'b0, cyc);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        after_abort("t4");
        drain("t4");
        check_ram("t4_ram");
        check("t4_starts", start_cnt, exp_starts);

        // iStart and iKey_valid held through DONE: reload with 0xFF.
        for (int i = 0; i < B; i++) key[i] = 8'($urandom);
        pulse_start();
        wait_ready("t5a");
        feed("t5a", B, 1'b1, cyc);
        iStart = 1'b1;
        bus.iKey_valid = 1'b1;
        bus.iKey_byte = 8'hFF;
        finish_load("t5a");
        model_sweep();
        tick();
        iStart = 1'b0;
        check("t5_done_drop", oDone, 1'b0);
        check("t5_no_start", oStartExpander, 1'b0);
        for (int i = 0; i < B; i++) key[i] = 8'hFF;
        wait_ready("t5b");
        feed("t5b", B, 1'b0, cyc);
        finish_load("t5b");
        tick();
        drain("t5");
        check_ram("t5_ram");
        check("t5_starts", start_cnt, exp_starts);

        // Reset while byte index 9 is offered.
        for (int i = 0; i < B; i++) key[i] = 8'($urandom);
        pulse_start();
        wait_ready("t6");
        feed("t6", 9, 1'b0, cyc);
        bus.iKey_valid = 1'b1;
        bus.iKey_byte = key[9];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_ready", bus.oKey_ready, 1'b0);
        check("t6_addr", bus.oKey_address, 0);
        check("t6_data", bus.oKey_data, 8'h00);
        check("t6_we", bus.oKey_we, 1'b0);
        check("t6_start", oStartExpander, 1'b0);
        check("t6_busy", oBusy, 1'b0);
        check("t6_done", oDone, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_idle_ready", bus.oKey_ready, 1'b0);
            check("t6_idle_we", bus.oKey_we, 1'b0);
        end
        bus.iKey_valid = 1'b0;
        drain("t6");
        check_ram("t6_ram");
        check("t6_starts", start_cnt, exp_starts);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
